rst_sequencer: RTL
==================

RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 100, clk_in cycles per tick (>=2).
REQ-002 SHALL have parameter N_CH, default 2, number of sequenced reset channels (1..8).
REQ-003 SHALL have parameter CNT_W, default 30, width of tick counter, period_in and hold_in.
REQ-004 SHALL have parameter STAGGER, default 16, ticks between successive channel releases.
REQ-005 SHALL have port clk_in  input  1  sole clock.
REQ-006 SHALL have port rst_in  input  1  synchronous, active-high reset.
REQ-007 SHALL have port en_in  input  1  periodic operation enable.
REQ-008 SHALL have port mode_in  input  1  0 = one-shot on trig_in, 1 = periodic.
REQ-009 SHALL have port trig_in  input  1  manual sequence request, level-sampled each cycle.
REQ-010 SHALL have port period_in  input  CNT_W  sequence period in ticks.
REQ-011 SHALL have port hold_in  input  CNT_W  all-channel assert time in ticks.
REQ-012 SHALL have port rst_out  output  N_CH  per-channel downstream resets, active-high, registered.
REQ-013 SHALL have port busy_out  output  1  high in ASSERT or RELEASE.
REQ-014 SHALL have port led_out  output  1  low while any rst_out bit high, else high.
REQ-015 SHALL have port tick_out  output  1  one-cycle prescaler tick pulse.

Function
REQ-016 SHALL run a prescaler counting 0..CLK_DIV-1; tick_out high for the one cycle the count equals CLK_DIV-1; prescaler and phase counter pc clear to 0 on every entry to ASSERT.
REQ-017 SHALL implement states IDLE, ASSERT, RELEASE, WAIT.
REQ-018 SHALL enter ASSERT at cycle T; rst_out all ones from T onward.
REQ-019 SHALL increment pc on each tick in ASSERT, RELEASE and WAIT; pc saturates at all ones.
REQ-020 SHALL use hold_eff = max(hold_in,1); ASSERT -> RELEASE when pc reaches hold_eff, i.e. at T+hold_eff*CLK_DIV.
REQ-021 SHALL clear rst_out[k] at cycle T+(hold_eff+k*STAGGER)*CLK_DIV; channel 0 releases first and bits never re-assert before the next ASSERT.
REQ-022 SHALL leave RELEASE when all channels are cleared: to WAIT if mode_in=1 and en_in=1, else IDLE.
REQ-023 SHALL go WAIT -> ASSERT at T+period_in*CLK_DIV; if period_in <= hold_eff+(N_CH-1)*STAGGER, the next ASSERT is one tick after the last release.
REQ-024 SHALL in IDLE or WAIT, on trig_in=1, enter ASSERT next cycle (latency 1), regardless of mode_in/en_in.
REQ-025 SHALL ignore trig_in in ASSERT and RELEASE.
REQ-026 SHALL go WAIT -> IDLE next cycle when en_in=0 or mode_in=0; in IDLE with mode_in=1 and en_in=1, enter ASSERT next cycle.
REQ-027 SHALL sample period_in/hold_in continuously; changes take effect on the current comparison; all comparisons are computed in CNT_W+1 bits without overflow.

Reset
REQ-028 SHALL, while rst_in=1, force state ASSERT, pc=0, prescaler=0, rst_out all ones, busy_out=1, led_out=0, tick_out=0.
REQ-029 SHALL treat the first cycle with rst_in=0 as cycle T of a full sequence (power-on sequencing); reset mid-sequence restarts it.

Structure
REQ-030 SHALL place the state enum and parameter defaults in package rst_seq_pkg.
REQ-031 SHALL implement the prescaler as sub-module tick_prescaler (CLK_DIV parameter, sync clear input, tick output).

Verification (CLK_DIV=4, N_CH=3, STAGGER=2, hold_in=3, period_in=20)
REQ-032 SHALL cover power-on: rst_in low at cycle 0 -> rst_out[0] clears at cycle 12, [1] at 20, [2] at 28; busy_out low from 28; led_out high from 28.
REQ-033 SHALL cover periodic mode: mode_in=1, en_in=1 -> rst_out=111 again at cycle 80 and 160.
REQ-034 SHALL cover short period: period_in=5 -> next ASSERT at cycle 32.
REQ-035 SHALL cover one-shot: mode_in=0, trig_in pulse at cycle 100 in IDLE -> rst_out=111 at 101, releases at 113/121/129; trig_in at 105 ignored.
REQ-036 SHALL cover reset mid-sequence: rst_in high at cycle 16 for 2 cycles -> rst_out=111 at 17, sequence restarts with T=18, [0] clears at 30.
REQ-037 SHALL cover hold_in=0: behaves as hold_in=1, rst_out[0] clears at T+4.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and parameter defaults for the reset sequencer.
package rst_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_RELEASE = 2'd2,
      ST_WAIT    = 2'd3
   } seq_state_t;

   localparam int unsigned CLK_DIV_DEF = 100;
   localparam int unsigned N_CH_DEF    = 2;
   localparam int unsigned CNT_W_DEF   = 30;
   localparam int unsigned STAGGER_DEF = 16;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..CLK_DIV-1 counter producing a one-cycle tick at the top
// count; clr restarts the count at 0 on the following cycle.
module tick_prescaler
   import rst_seq_pkg::*;
#(
   parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
   input  logic clk_in,
   input  logic clr,
   output logic tick
);

   localparam int unsigned DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;

   // count up, wrap at DIV_MAX, restart on clear
   always_ff @(posedge clk_in) begin
      if (clr)
         div_cnt <= '0;
      else if (div_cnt == DIV_MAX)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + 1'b1;
   end

   assign tick = (div_cnt == DIV_MAX);

endmodule

// File: rtl/rst_sequencer.sv
// Staggered multi-channel reset sequencer: all channels assert together,
// then release one by one STAGGER ticks apart, one-shot or periodic.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | all channels released, waiting for trig or periodic enable
//   ST_ASSERT  | all channels held in reset until pc reaches hold_eff
//   ST_RELEASE | channels dropping out of reset in order, channel 0 first
//   ST_WAIT    | all released, waiting for pc to reach period_in
module rst_sequencer
   import rst_seq_pkg::*;
#(
   parameter int unsigned CLK_DIV = CLK_DIV_DEF,
   parameter int unsigned N_CH    = N_CH_DEF,
   parameter int unsigned CNT_W   = CNT_W_DEF,
   parameter int unsigned STAGGER = STAGGER_DEF
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             en_in,
   input  logic             mode_in,
   input  logic             trig_in,
   input  logic [CNT_W-1:0] period_in,
   input  logic [CNT_W-1:0] hold_in,
   output logic [N_CH-1:0]  rst_out,
   output logic             busy_out,
   output logic             led_out,
   output logic             tick_out
);

   // one extra bit so hold_eff + k*STAGGER cannot wrap for any CNT_W-wide hold
   localparam int unsigned CMP_W = CNT_W + 1;

   seq_state_t       state, state_nxt;
   logic [CNT_W-1:0] pc, pc_inc, pc_nxt;
   logic [N_CH-1:0]  rst_nxt;
   logic             tick, presc_clr;
   logic [CMP_W-1:0] hold_eff, period_cmp, pc_cmp;
   logic [CMP_W-1:0] rel_at [N_CH];

   tick_prescaler #(
      .CLK_DIV (CLK_DIV)
   ) u_presc (
      .clk_in (clk_in),
      .clr    (presc_clr | rst_in),
      .tick   (tick)
   );

   assign hold_eff   = (hold_in == '0) ? CMP_W'(1) : {1'b0, hold_in};
   assign period_cmp = {1'b0, period_in};
   assign pc_inc     = (tick && (pc != '1)) ? pc + 1'b1 : pc;
   assign pc_cmp     = {1'b0, pc_inc};

   // per-channel release thresholds in ticks since entry to ASSERT
   always_comb begin
      for (int k = 0; k < int'(N_CH); k++)
         rel_at[k] = hold_eff + CMP_W'(k * STAGGER);
   end

   // next state, next pc and next channel resets; decisions use the
   // post-tick pc so a release lands on the same cycle pc reaches its threshold
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc_inc;
      rst_nxt   = rst_out;
      presc_clr = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (trig_in || (mode_in && en_in)) begin
               state_nxt = ST_ASSERT;
               pc_nxt    = '0;
               rst_nxt   = '1;
               presc_clr = 1'b1;
            end
         end
         ST_ASSERT, ST_RELEASE: begin
            for (int k = 0; k < int'(N_CH); k++)
               if (pc_cmp >= rel_at[k])
                  rst_nxt[k] = 1'b0;
            if (rst_nxt == '0)
               state_nxt = (mode_in && en_in) ? ST_WAIT : ST_IDLE;
            else if (pc_cmp >= hold_eff)
               state_nxt = ST_RELEASE;
         end
         ST_WAIT: begin
            if (trig_in || (tick && mode_in && en_in && (pc_cmp >= period_cmp))) begin
               state_nxt = ST_ASSERT;
               pc_nxt    = '0;
               rst_nxt   = '1;
               presc_clr = 1'b1;
            end else if (!en_in || !mode_in) begin
               state_nxt = ST_IDLE;
            end
         end
      endcase
   end

   // state, phase counter and channel reset registers; reset starts a full sequence
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state   <= ST_ASSERT;
         pc      <= '0;
         rst_out <= '1;
      end else begin
         state   <= state_nxt;
         pc      <= pc_nxt;
         rst_out <= rst_nxt;
      end
   end

   assign busy_out = rst_in || (state == ST_ASSERT) || (state == ST_RELEASE);
   assign led_out  = !rst_in && (rst_out == '0);
   assign tick_out = tick && !rst_in;

endmodule
